// File: rtl/alu_wb_buffer_if.sv
// alu_wb_buffer_if
//   Bundles the producer-side (mux result in) and consumer-side (register-file
//   writeback out) signals of the writeback buffer.
//   Parameter N : result width.
//   Modports:
//     slave  - the buffer: takes res_in/fn_sel/rd_in/in_valid/wb_ready,
//              drives in_ready and the wb_* head outputs.
//     master - the environment: the mirror image of slave.
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both 1; valid is not made to depend on ready, and ready never depends
//   combinationally on valid (it is a function of registered state only).
interface alu_wb_buffer_if #(
   parameter int N = 16
) ();
   logic [N-1:0] res_in;
   logic [4:0]   fn_sel;
   logic [3:0]   rd_in;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] wb_data;
   logic [3:0]   wb_fn;
   logic [3:0]   wb_rd;
   logic         wb_zero;
   logic         wb_neg;
   logic         wb_valid;
   logic         wb_ready;

   modport slave (
      input  res_in, fn_sel, rd_in, in_valid, wb_ready,
      output in_ready, wb_data, wb_fn, wb_rd, wb_zero, wb_neg, wb_valid
   );

   modport master (
      output res_in, fn_sel, rd_in, in_valid, wb_ready,
      input  in_ready, wb_data, wb_fn, wb_rd, wb_zero, wb_neg, wb_valid
   );
endinterface

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer
//   Writeback stage behind the 16:1 function-result mux. Holds up to two
//   results (with fn_sel[3:0] and destination register) in a FIFO and hands
//   them to the register-file write port. Pushes whose fn_sel[4] is set are
//   illegal selects: the handshake completes but nothing is stored; they set
//   the sticky sel_err flag and bump the saturating err_cnt.
//   Optional feature macro: WB_FLAGS_EN - when defined, each entry also stores
//   zero/negative flags computed at push time, driving wb_zero/wb_neg. When
//   undefined, no flag storage exists and wb_zero/wb_neg are tied to 0.
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   bus      : alu_wb_buffer_if.slave (input side and writeback side)
//   err_clr  : synchronous clear of sel_err/err_cnt
//   sel_err  : sticky illegal-select flag
//   err_cnt  : illegal-select count, saturates at 255
module alu_wb_buffer #(
   parameter int N = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_wb_buffer_if.slave        bus,
   input  logic                  err_clr,
   output logic                  sel_err,
   output logic [7:0]            err_cnt
);
   localparam int DEPTH = 2;

   logic [N-1:0] mem_data [DEPTH];
   logic [3:0]   mem_fn   [DEPTH];
   logic [3:0]   mem_rd   [DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;

   logic push;
   logic pop;
   logic illegal;
   logic wr_en;

   // Ready comes only from registered count: a full buffer refuses a push
   // even when the head is popped in the same cycle.
   assign bus.in_ready = (count < 2'd2);
   assign bus.wb_valid = (count != 2'd0);

   assign push    = bus.in_valid & bus.in_ready;
   assign pop     = bus.wb_valid & bus.wb_ready;
   assign illegal = push & bus.fn_sel[4];
   assign wr_en   = push & ~bus.fn_sel[4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_fn[i]   <= '0;
            mem_rd[i]   <= '0;
         end
      end else begin
         if (wr_en) begin
            mem_data[wr_ptr] <= bus.res_in;
            mem_fn[wr_ptr]   <= bus.fn_sel[3:0];
            mem_rd[wr_ptr]   <= bus.rd_in;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({wr_en, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Head outputs are forced to zero whenever the buffer is empty.
   assign bus.wb_data = bus.wb_valid ? mem_data[rd_ptr] : '0;
   assign bus.wb_fn   = bus.wb_valid ? mem_fn[rd_ptr]   : '0;
   assign bus.wb_rd   = bus.wb_valid ? mem_rd[rd_ptr]   : '0;

`ifdef WB_FLAGS_EN
   logic mem_zero [DEPTH];
   logic mem_neg  [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_zero[i] <= 1'b0;
            mem_neg[i]  <= 1'b0;
         end
      end else if (wr_en) begin
         mem_zero[wr_ptr] <= (bus.res_in == '0);
         mem_neg[wr_ptr]  <= bus.res_in[N-1];
      end
   end

   assign bus.wb_zero = bus.wb_valid & mem_zero[rd_ptr];
   assign bus.wb_neg  = bus.wb_valid & mem_neg[rd_ptr];
`else
   assign bus.wb_zero = 1'b0;
   assign bus.wb_neg  = 1'b0;
`endif

   // A clear wins over history but not over an illegal push in the same
   // cycle: that push is counted as the first error after the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err <= 1'b0;
         err_cnt <= 8'd0;
      end else if (err_clr) begin
         sel_err <= illegal;
         err_cnt <= illegal ? 8'd1 : 8'd0;
      end else if (illegal) begin
         sel_err <= 1'b1;
         if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_alu_wb_buffer.sv
module tb_alu_wb_buffer;
   localparam int N = 16;
   localparam int W = N + 8;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       err_clr;
   logic       sel_err;
   logic [7:0] err_cnt;

   always #5 clk = ~clk;

   alu_wb_buffer_if #(.N(N)) bus ();

   alu_wb_buffer #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .err_clr (err_clr),
      .sel_err (sel_err),
      .err_cnt (err_cnt)
   );

   // ---------------- scoreboard ----------------
   // Each entry packs {data, fn[3:0], rd}.
   logic [W-1:0] exp_q[$];
   logic         exp_err;
   int           exp_cnt;
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [W-1:0] head;
      logic         have;
      logic         exp_zero;
      logic         exp_neg;
      have = (exp_q.size() > 0);
      head = have ? exp_q[0] : '0;
`ifdef WB_FLAGS_EN
      exp_zero = have && (head[W-1:8] == '0);
      exp_neg  = have && head[W-1];
`else
      exp_zero = 1'b0;
      exp_neg  = 1'b0;
`endif
      check("wb_valid", 32'(bus.wb_valid), 32'(have));
      check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
      check("wb_data",  32'(bus.wb_data),  32'(head[W-1:8]));
      check("wb_fn",    32'(bus.wb_fn),    32'(head[7:4]));
      check("wb_rd",    32'(bus.wb_rd),    32'(head[3:0]));
      check("wb_zero",  32'(bus.wb_zero),  32'(exp_zero));
      check("wb_neg",   32'(bus.wb_neg),   32'(exp_neg));
      check("sel_err",  32'(sel_err),      32'(exp_err));
      check("err_cnt",  32'(err_cnt),      32'(exp_cnt));
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of inputs (called just after a falling edge), advances
   // the reference model by the same cycle, then checks at the next falling edge.
   task automatic step(input logic iv, input logic [N-1:0] d, input logic [4:0] f,
                       input logic [3:0] r, input logic wr, input logic clr);
      logic push;
      logic pop;
      logic bad;
      bus.in_valid = iv;
      bus.res_in   = d;
      bus.fn_sel   = f;
      bus.rd_in    = r;
      bus.wb_ready = wr;
      err_clr      = clr;
      push = iv && (exp_q.size() < 2);
      pop  = wr && (exp_q.size() > 0);
      bad  = push && f[4];
      if (pop) void'(exp_q.pop_front());
      if (push && !f[4]) exp_q.push_back({d, f[3:0], r});
      if (clr) begin
         exp_err = bad;
         exp_cnt = bad ? 1 : 0;
      end else if (bad) begin
         exp_err = 1'b1;
         if (exp_cnt < 255) exp_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input logic wr);
      step(1'b0, '0, 5'd0, 4'd0, wr, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      err_clr = 1'b0;
      bus.in_valid = 1'b0;
      bus.res_in = '0;
      bus.fn_sel = '0;
      bus.rd_in = '0;
      bus.wb_ready = 1'b0;
      exp_err = 1'b0;
      exp_cnt = 0;
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b0;
      @(negedge clk);

      // Single pass
      step(1'b1, 16'h1234, 5'd3, 4'd5, 1'b1, 1'b0);
      check("single_data", 32'(bus.wb_data), 32'h1234);
      check("single_fn", 32'(bus.wb_fn), 32'd3);
      check("single_rd", 32'(bus.wb_rd), 32'd5);
      idle(1'b1);
      check("single_gone", 32'(bus.wb_valid), 32'd0);

      // Backpressure, full refusal, in-order drain
      step(1'b1, 16'hAAAA, 5'd1, 4'd1, 1'b0, 1'b0);
      step(1'b1, 16'h5555, 5'd2, 4'd2, 1'b0, 1'b0);
      check("full_not_ready", 32'(bus.in_ready), 32'd0);
      step(1'b1, 16'h1111, 5'd3, 4'd3, 1'b0, 1'b0);
      check("refused_head", 32'(bus.wb_data), 32'hAAAA);
      // Full plus simultaneous pop: pop only
      step(1'b1, 16'h7777, 5'd4, 4'd4, 1'b1, 1'b0);
      check("full_pop_ready", 32'(bus.in_ready), 32'd1);
      check("full_pop_head", 32'(bus.wb_data), 32'h5555);
      idle(1'b1);
      check("drained", 32'(bus.wb_valid), 32'd0);

      // Illegal selects
      repeat (3) step(1'b1, 16'hBEEF, 5'd17, 4'd6, 1'b1, 1'b0);
      check("illegal_no_valid", 32'(bus.wb_valid), 32'd0);
      check("illegal_sel_err", 32'(sel_err), 32'd1);
      check("illegal_cnt3", 32'(err_cnt), 32'd3);
      step(1'b1, 16'hBEEF, 5'd17, 4'd6, 1'b1, 1'b1);
      check("clr_with_illegal", 32'(err_cnt), 32'd1);
      step(1'b0, '0, 5'd0, 4'd0, 1'b1, 1'b1);
      check("clr_only", 32'(sel_err), 32'd0);

      // Saturation
      repeat (260) step(1'b1, 16'h0F0F, 5'd31, 4'd0, 1'b1, 1'b0);
      check("cnt_saturated", 32'(err_cnt), 32'hFF);

      // Flags
      step(1'b1, 16'h0000, 5'd7, 4'd8, 1'b0, 1'b0);
      step(1'b1, 16'h8001, 5'd8, 4'd9, 1'b1, 1'b0);
      idle(1'b1);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         logic [4:0] f;
         f = ($urandom_range(0, 7) == 0) ? 5'(16 + $urandom_range(0, 15))
                                         : 5'($urandom_range(0, 15));
         step(1'($urandom_range(0, 1)), N'($urandom), f, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
      end

      // Mid-run reset with two entries held and a nonzero error count
      step(1'b1, 16'h2222, 5'd20, 4'd1, 1'b0, 1'b1);
      step(1'b1, 16'h3333, 5'd1, 4'd1, 1'b0, 1'b0);
      step(1'b1, 16'h4444, 5'd2, 4'd2, 1'b0, 1'b0);
      check("pre_reset_full", 32'(bus.in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus.wb_valid), 32'd0);
      check("async_rst_ready", 32'(bus.in_ready), 32'd1);
      check("async_rst_cnt", 32'(err_cnt), 32'd0);
      check("async_rst_data", 32'(bus.wb_data), 32'd0);
      exp_q.delete();
      exp_err = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
